// File: rtl/bcd_edit_pkg.sv
// Shared types and BCD helpers for the field editor: FSM state encoding,
// BCD carry/borrow adjust constants and the field validity check.
package bcd_edit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EDIT   = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam logic [7:0] BCD_ADJ  = 8'h07;
    localparam logic [3:0] BCD_NINE = 4'h9;

    // A field is usable only if both digits are decimal and it lies inside its range.
    function automatic logic bcd_valid(input logic [7:0] v,
                                       input logic [7:0] lo,
                                       input logic [7:0] hi);
        return (v[7:4] <= BCD_NINE) && (v[3:0] <= BCD_NINE) && (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational one-step increment/decrement of a two-digit BCD field with
// per-field wrap limits; up and down together leave the value unchanged.
module bcd_step
    import bcd_edit_pkg::*;
(
    input  logic [7:0] value,
    input  logic [7:0] min,
    input  logic [7:0] max,
    input  logic       up,
    input  logic       down,
    output logic [7:0] next_value
);

    always_comb begin
        next_value = value;
        if (up && !down) begin
            if (value >= max)
                next_value = min;
            else if (value[3:0] == BCD_NINE)
                next_value = value + BCD_ADJ;   // x9 + 07 lands on (x+1)0
            else
                next_value = value + 8'h01;
        end else if (down && !up) begin
            if (value <= min)
                next_value = max;
            else if (value[3:0] == 4'h0)
                next_value = value - BCD_ADJ;   // x0 - 07 lands on (x-1)9
            else
                next_value = value - 8'h01;
        end
    end

endmodule

// File: rtl/bcd_field_editor.sv
// User edit controller for packed two-digit BCD fields: snapshot, cursor, step, commit.
// Define FIELD_EDIT_REPEAT_EN to enable up/down auto-repeat while a step button is held.
module bcd_field_editor
    import bcd_edit_pkg::*;
#(
    parameter int                       NFIELDS       = 6,
    parameter logic [8*NFIELDS-1:0]     FIELD_MIN     = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01},
    parameter logic [8*NFIELDS-1:0]     FIELD_MAX     = {8'h59, 8'h59, 8'h23, 8'h99, 8'h12, 8'h31},
    parameter int                       REPEAT_DELAY  = 50_000_000,
    parameter int                       REPEAT_PERIOD = 10_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        btn_start,
    input  logic                        btn_commit,
    input  logic                        btn_cancel,
    input  logic                        btn_left,
    input  logic                        btn_right,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic [8*NFIELDS-1:0]        cur_vals_i,
    output logic [8*NFIELDS-1:0]        vals_o,
    output logic [$clog2(NFIELDS)-1:0]  cursor_o,
    output logic                        editing_o,
    output logic                        commit_o,
    output logic [1:0]                  dbg_state
);

    localparam int CW = $clog2(NFIELDS);

    if (NFIELDS < 2 || NFIELDS > 16 || REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_cfg
        $error("bcd_field_editor: unsupported parameter set");
    end

    state_e     state, next_state;
    logic [6:0] btn_q;
    logic [6:0] lvl, rise;
    logic       rise_start, rise_commit, rise_cancel, rise_left, rise_right, rise_up, rise_down;
    logic       nav, step_up, step_down, edit_active;
    logic [7:0] stepped;

    assign lvl = {btn_start, btn_commit, btn_cancel, btn_left, btn_right, btn_up, btn_down};
    assign rise = lvl & ~btn_q;
    assign {rise_start, rise_commit, rise_cancel, rise_left, rise_right, rise_up, rise_down} = rise;

    assign nav         = rise_left | rise_right;
    assign edit_active = (state == EDIT) && !rise_commit && !rise_cancel;
    assign dbg_state   = state;

`ifdef FIELD_EDIT_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_fire;

    assign rep_fire  = (rep_cnt == RW'(REPEAT_DELAY));
    assign step_up   = rise_up   | (rep_fire & btn_up);
    assign step_down = rise_down | (rep_fire & btn_down);

    // Counter only arms on a fresh rise, so a button held on entry never repeats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rep_cnt <= '0;
        else if (!edit_active || nav || !(btn_up ^ btn_down))
            rep_cnt <= '0;
        else if (rise_up || rise_down)
            rep_cnt <= RW'(1);
        else if (rep_fire)
            rep_cnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        else if (rep_cnt != '0)
            rep_cnt <= rep_cnt + RW'(1);
    end
`else
    assign step_up   = rise_up;
    assign step_down = rise_down;
`endif

    bcd_step u_step (
        .value      (vals_o[8*cursor_o +: 8]),
        .min        (FIELD_MIN[8*cursor_o +: 8]),
        .max        (FIELD_MAX[8*cursor_o +: 8]),
        .up         (step_up),
        .down       (step_down),
        .next_value (stepped)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (rise_start) next_state = LOAD;
            LOAD:    next_state = EDIT;
            EDIT: begin
                if (rise_commit)      next_state = COMMIT;
                else if (rise_cancel) next_state = IDLE;
            end
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            btn_q     <= '0;
            vals_o    <= '0;
            cursor_o  <= '0;
            editing_o <= 1'b0;
            commit_o  <= 1'b0;
        end else begin
            state     <= next_state;
            btn_q     <= lvl;
            editing_o <= (next_state == LOAD) || (next_state == EDIT);
            commit_o  <= (next_state == COMMIT);
            if (state == LOAD) begin
                cursor_o <= '0;
                for (int i = 0; i < NFIELDS; i++) begin
                    vals_o[8*i +: 8] <= bcd_valid(cur_vals_i[8*i +: 8], FIELD_MIN[8*i +: 8], FIELD_MAX[8*i +: 8])
                                        ? cur_vals_i[8*i +: 8] : FIELD_MIN[8*i +: 8];
                end
            end else if (edit_active) begin
                // A navigation rise swallows any step on the same cycle.
                if (nav) begin
                    if (rise_right && !rise_left)
                        cursor_o <= (cursor_o == CW'(NFIELDS - 1)) ? '0 : cursor_o + CW'(1);
                    else if (rise_left && !rise_right)
                        cursor_o <= (cursor_o == '0) ? CW'(NFIELDS - 1) : cursor_o - CW'(1);
                end else if (step_up || step_down) begin
                    vals_o[8*cursor_o +: 8] <= stepped;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_field_editor.sv
// Directed bench for bcd_field_editor; commit payloads are checked through an expected queue.
// Build with FIELD_EDIT_REPEAT_EN defined to exercise auto-repeat expectations.
module tb_bcd_field_editor;

    localparam logic [6:0] B_START  = 7'b1000000;
    localparam logic [6:0] B_COMMIT = 7'b0100000;
    localparam logic [6:0] B_CANCEL = 7'b0010000;
    localparam logic [6:0] B_LEFT   = 7'b0001000;
    localparam logic [6:0] B_RIGHT  = 7'b0000100;
    localparam logic [6:0] B_UP     = 7'b0000010;
    localparam logic [6:0] B_DOWN   = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_start, btn_commit, btn_cancel, btn_left, btn_right, btn_up, btn_down;
    logic [47:0] cur_vals;
    logic [47:0] vals;
    logic [2:0]  cursor;
    logic        editing, commit;
    logic [1:0]  dbg_state;

    int          tests = 0;
    int          fails = 0;
    int          commits = 0;
    logic [47:0] exp_q[$];

    bcd_field_editor #(
        .NFIELDS       (6),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_start  (btn_start),
        .btn_commit (btn_commit),
        .btn_cancel (btn_cancel),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .cur_vals_i (cur_vals),
        .vals_o     (vals),
        .cursor_o   (cursor),
        .editing_o  (editing),
        .commit_o   (commit),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] field(input int i);
        return vals[8*i +: 8];
    endfunction

    // driver
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] m);
        {btn_start, btn_commit, btn_cancel, btn_left, btn_right, btn_up, btn_down} = m;
    endtask

    task automatic press(input logic [6:0] m);
        drive(m);
        tick();
        drive(7'b0);
        tick();
    endtask

    // scoreboard: every commit strobe pops one expected payload
    always @(negedge clk) begin
        if (commit === 1'b1) begin
            commits++;
            if (exp_q.size() == 0)
                check("commit_unexpected", 48'd1, 48'd0);
            else
                check("commit_vals", vals, exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        drive(7'b0);
        cur_vals = '0;
        tick();
        tick();
        check("rst_vals",    vals,      48'h0);
        check("rst_cursor",  48'(cursor), 48'd0);
        check("rst_editing", 48'(editing), 48'd0);
        check("rst_commit",  48'(commit), 48'd0);
        check("rst_state",   48'(dbg_state), 48'd0);
        reset = 1'b0;
        tick();

        // load clamp: day 00 and month 1A are replaced by their minimums
        cur_vals = 48'h30_45_15_24_1A_00;
        press(B_START);
        check("load_state",   48'(dbg_state), 48'd2);
        check("load_editing", 48'(editing), 48'd1);
        check("load_vals",    vals, 48'h30_45_15_24_01_01);
        check("load_cursor",  48'(cursor), 48'd0);

        // day wrap and BCD carry/borrow
        press(B_DOWN);
        check("day_01_down", 48'(field(0)), 48'h31);
        press(B_UP);
        check("day_31_up",   48'(field(0)), 48'h01);
        for (int i = 0; i < 18; i++) press(B_UP);
        check("day_to_19",   48'(field(0)), 48'h19);
        press(B_UP);
        check("day_19_up",   48'(field(0)), 48'h20);
        press(B_DOWN);
        check("day_20_down", 48'(field(0)), 48'h19);

        // cursor wrap and simultaneous buttons
        press(B_LEFT);
        check("left_wrap",   48'(cursor), 48'd5);
        press(B_LEFT | B_RIGHT);
        check("left_right",  48'(cursor), 48'd5);
        press(B_RIGHT | B_UP);
        check("right_up_cursor", 48'(cursor), 48'd0);
        check("right_up_vals",   vals, 48'h30_45_15_24_01_19);
        press(B_UP | B_DOWN);
        check("up_down_same",    48'(field(0)), 48'h19);

        // edit min to 42 and commit
        for (int i = 0; i < 4; i++) press(B_RIGHT);
        check("cursor_min",  48'(cursor), 48'd4);
        for (int i = 0; i < 3; i++) press(B_DOWN);
        check("min_42",      48'(field(4)), 48'h42);
        exp_q.push_back(48'h30_42_15_24_01_19);
        press(B_COMMIT);
        check("post_commit_state",   48'(dbg_state), 48'd0);
        check("post_commit_editing", 48'(editing), 48'd0);
        check("commit_count_1",      48'(commits), 48'd1);

        // edit then cancel: no strobe, abandoned values remain visible
        press(B_START);
        for (int i = 0; i < 4; i++) press(B_RIGHT);
        press(B_UP);
        press(B_CANCEL);
        check("cancel_state", 48'(dbg_state), 48'd0);
        check("cancel_vals",  vals, 48'h30_46_15_24_01_01);
        check("cancel_no_commit", 48'(commits), 48'd1);

        // held up on sec = 57
        cur_vals = 48'h57_45_15_24_1A_00;
        press(B_START);
        press(B_LEFT);
        check("cursor_sec", 48'(cursor), 48'd5);
        drive(B_UP);
        repeat (22) tick();
        drive(7'b0);
        tick();
`ifdef FIELD_EDIT_REPEAT_EN
        check("hold_sec", 48'(field(5)), 48'h01);
`else
        check("hold_sec", 48'(field(5)), 48'h58);
`endif
        press(B_CANCEL);

        // asynchronous reset mid-edit
        press(B_START);
        for (int i = 0; i < 3; i++) press(B_RIGHT);
        check("pre_rst_cursor", 48'(cursor), 48'd3);
        check("pre_rst_hour",   48'(field(3)), 48'h15);
        reset = 1'b1;
        #1;
        check("mid_rst_vals",    vals, 48'h0);
        check("mid_rst_cursor",  48'(cursor), 48'd0);
        check("mid_rst_editing", 48'(editing), 48'd0);
        check("mid_rst_commit",  48'(commit), 48'd0);
        check("mid_rst_state",   48'(dbg_state), 48'd0);
        tick();
        reset = 1'b0;
        tick();

        check("final_commits", 48'(commits), 48'd1);
        check("final_queue",   48'(exp_q.size()), 48'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
